// File: rtl/clint_if.sv
`default_nettype none
// ============================================================================
// Module   : clint_if
// Brief    : APB bus bundle between the fabric target port and the CLINT.
// Revision : 1.0
// ============================================================================
interface clint_if #(
    parameter int ADDR_W = 16
);
    logic              psel;
    logic              penable;
    logic              pready;
    logic [ADDR_W-1:0] paddr;
    logic              pwrite;
    logic [31:0]       pwdata;
    logic [3:0]        pwstrb;
    logic [31:0]       prdata;
    logic              pslverr;

    modport master (
        output psel, penable, paddr, pwrite, pwdata, pwstrb,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  psel, penable, paddr, pwrite, pwdata, pwstrb,
        output pready, prdata, pslverr
    );
endinterface
`default_nettype wire

// File: rtl/clint.sv
`default_nettype none
// ============================================================================
// Module   : clint
// Brief    : Core-local interruptor: 64-bit mtime, mtimecmp and msip on APB,
//            driving registered mtip/msip. Macro CLINT_SNAPSHOT_EN adds a
//            shadow of mtime[63:32] for tear-free LO-then-HI reads.
// Revision : 1.0
// ============================================================================
module clint #(
    parameter int ADDR_W   = 16,
    parameter int TICK_DIV = 1
) (
    input  logic   clk,
    input  logic   rst_n,
    clint_if.slave apb,
    output logic   mtip,
    output logic   msip
);
    localparam logic [ADDR_W-1:0] c_msip_addr   = ADDR_W'(16'h0000);
    localparam logic [ADDR_W-1:0] c_cmp_lo_addr = ADDR_W'(16'h4000);
    localparam logic [ADDR_W-1:0] c_cmp_hi_addr = ADDR_W'(16'h4004);
    localparam logic [ADDR_W-1:0] c_mt_lo_addr  = ADDR_W'(16'hBFF8);
    localparam logic [ADDR_W-1:0] c_mt_hi_addr  = ADDR_W'(16'hBFFC);
    localparam logic [15:0]       c_presc_last  = 16'(TICK_DIV - 1);

    logic [63:0] mtime_q, mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic [15:0] presc_q, presc_d;
    logic        msip_q, msip_d;
    logic        mtip_q, mtip_d;

    logic        access, hit, wr_en, rd_en, tick;
    logic        sel_msip, sel_cmp_lo, sel_cmp_hi, sel_mt_lo, sel_mt_hi;
    logic [63:0] mtime_adv;
    logic [31:0] mtime_hi_rd;

    function automatic logic [31:0] merge_lanes(
        input logic [31:0] old_v,
        input logic [31:0] new_v,
        input logic [3:0]  strb
    );
        logic [31:0] res;
        res = old_v;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) res[8*i +: 8] = new_v[8*i +: 8];
        end
        return res;
    endfunction

    // Exact-match decode: every mapped offset is word aligned, so any
    // misaligned or unmapped address simply misses.
    always_comb begin
        access     = apb.psel && apb.penable;
        sel_msip   = (apb.paddr == c_msip_addr);
        sel_cmp_lo = (apb.paddr == c_cmp_lo_addr);
        sel_cmp_hi = (apb.paddr == c_cmp_hi_addr);
        sel_mt_lo  = (apb.paddr == c_mt_lo_addr);
        sel_mt_hi  = (apb.paddr == c_mt_hi_addr);
        hit        = sel_msip | sel_cmp_lo | sel_cmp_hi | sel_mt_lo | sel_mt_hi;
        wr_en      = access && hit && apb.pwrite;
        rd_en      = access && hit && !apb.pwrite;
    end

    assign apb.pready  = 1'b1;
    assign apb.pslverr = access && !hit;

    always_comb begin
        tick       = (presc_q == c_presc_last);
        presc_d    = tick ? 16'd0 : presc_q + 16'd1;
        mtime_adv  = tick ? mtime_q + 64'd1 : mtime_q;
        mtime_d    = mtime_adv;
        mtimecmp_d = mtimecmp_q;
        msip_d     = msip_q;
        if (wr_en) begin
            if (sel_msip && apb.pwstrb[0]) msip_d = apb.pwdata[0];
            if (sel_cmp_lo) mtimecmp_d[31:0]  = merge_lanes(mtimecmp_q[31:0], apb.pwdata, apb.pwstrb);
            if (sel_cmp_hi) mtimecmp_d[63:32] = merge_lanes(mtimecmp_q[63:32], apb.pwdata, apb.pwstrb);
            // A LO write holds HI at its old value, dropping any carry.
            if (sel_mt_lo)  mtime_d = {mtime_q[63:32], merge_lanes(mtime_adv[31:0], apb.pwdata, apb.pwstrb)};
            if (sel_mt_hi)  mtime_d[63:32] = merge_lanes(mtime_adv[63:32], apb.pwdata, apb.pwstrb);
        end
        mtip_d = (mtime_q >= mtimecmp_q);
    end

`ifdef CLINT_SNAPSHOT_EN
    logic [31:0] shadow_q, shadow_d;

    always_comb begin
        shadow_d = shadow_q;
        if (rd_en && sel_mt_lo) shadow_d = mtime_q[63:32];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) shadow_q <= '0;
        else        shadow_q <= shadow_d;
    end

    assign mtime_hi_rd = shadow_q;
`else
    assign mtime_hi_rd = mtime_q[63:32];
`endif

    always_comb begin
        apb.prdata = '0;
        if (rd_en) begin
            if (sel_msip)        apb.prdata = {31'd0, msip_q};
            else if (sel_cmp_lo) apb.prdata = mtimecmp_q[31:0];
            else if (sel_cmp_hi) apb.prdata = mtimecmp_q[63:32];
            else if (sel_mt_lo)  apb.prdata = mtime_q[31:0];
            else                 apb.prdata = mtime_hi_rd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mtime_q    <= '0;
            mtimecmp_q <= '1;
            presc_q    <= '0;
            msip_q     <= 1'b0;
            mtip_q     <= 1'b0;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            presc_q    <= presc_d;
            msip_q     <= msip_d;
            mtip_q     <= mtip_d;
        end
    end

    assign mtip = mtip_q;
    assign msip = msip_q;
endmodule
`default_nettype wire

// File: tb/tb_clint.sv
`default_nettype none
// ============================================================================
// Module   : tb_clint
// Brief    : Scoreboard bench for clint (TICK_DIV=1 and TICK_DIV=4 instances).
// Revision : 1.0
// ============================================================================
module tb_clint;
    logic        clk;
    logic        rst_n;
    logic        b_psel, b_penable, b_pwrite, sel4;
    logic [15:0] b_paddr;
    logic [31:0] b_pwdata;
    logic [3:0]  b_pwstrb;
    logic        mtip1, msip1, mtip4, msip4;
    int unsigned cyc;
    int          total;
    int          bad;
    bit          ending;

`ifdef CLINT_SNAPSHOT_EN
    localparam logic [31:0] EXP_HI_TEAR = 32'd5;
`else
    localparam logic [31:0] EXP_HI_TEAR = 32'd6;
`endif

    typedef struct {
        bit          d4;
        bit          chk_data;
        logic [31:0] data;
        bit          err;
        string       name;
    } apb_exp_t;

    typedef struct {
        bit    chk_mtip;
        bit    mtip;
        bit    msip;
        string name;
    } irq_exp_t;

    apb_exp_t apb_q[$];
    irq_exp_t irq_q[$];

    clint_if #(.ADDR_W(16)) bus1 ();
    clint_if #(.ADDR_W(16)) bus4 ();

    assign bus1.psel    = b_psel & ~sel4;
    assign bus1.penable = b_penable & ~sel4;
    assign bus1.paddr   = b_paddr;
    assign bus1.pwrite  = b_pwrite;
    assign bus1.pwdata  = b_pwdata;
    assign bus1.pwstrb  = b_pwstrb;
    assign bus4.psel    = b_psel & sel4;
    assign bus4.penable = b_penable & sel4;
    assign bus4.paddr   = b_paddr;
    assign bus4.pwrite  = b_pwrite;
    assign bus4.pwdata  = b_pwdata;
    assign bus4.pwstrb  = b_pwstrb;

    clint #(.ADDR_W(16), .TICK_DIV(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .apb   (bus1),
        .mtip  (mtip1),
        .msip  (msip1)
    );

    clint #(.ADDR_W(16), .TICK_DIV(4)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .apb   (bus4),
        .mtip  (mtip4),
        .msip  (msip4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Rising edges since reset release; both DUTs count from the same point.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=0x%08h required=0x%08h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        apb_exp_t e;
        irq_exp_t q;
        logic     act1, act4;
        act1 = bus1.psel && bus1.penable;
        act4 = bus4.psel && bus4.penable;
        if (act1 || act4) begin
            if (apb_q.size() == 0) begin
                chk("unexpected_access", 32'd1, 32'd0);
            end else begin
                e = apb_q.pop_front();
                chk({e.name, "_pready"}, 32'(e.d4 ? bus4.pready : bus1.pready), 32'd1);
                chk({e.name, "_pslverr"}, 32'(e.d4 ? bus4.pslverr : bus1.pslverr), 32'(e.err));
                if (e.chk_data) chk({e.name, "_prdata"}, e.d4 ? bus4.prdata : bus1.prdata, e.data);
            end
        end
        if (irq_q.size() != 0) begin
            q = irq_q.pop_front();
            if (q.chk_mtip) chk({q.name, "_mtip"}, 32'(mtip1), 32'(q.mtip));
            chk({q.name, "_msip"}, 32'(msip1), 32'(q.msip));
        end
        if (ending) begin
            while (apb_q.size() != 0) begin
                e = apb_q.pop_front();
                chk({e.name, "_never_seen"}, 32'd0, 32'd1);
            end
            while (irq_q.size() != 0) begin
                q = irq_q.pop_front();
                chk({q.name, "_never_seen"}, 32'd0, 32'd1);
            end
        end
    end

    task automatic push_apb(input bit d4, input bit chk_data, input logic [31:0] data,
                            input bit err, input string name);
        apb_exp_t e;
        e.d4 = d4; e.chk_data = chk_data; e.data = data; e.err = err; e.name = name;
        apb_q.push_back(e);
    endtask

    task automatic irq(input bit chk_mtip, input bit mt, input bit ms, input string name);
        irq_exp_t q;
        q.chk_mtip = chk_mtip; q.mtip = mt; q.msip = ms; q.name = name;
        irq_q.push_back(q);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called at posedge+1: setup phase now, access phase after the next edge.
    task automatic apb(input bit d4, input logic [15:0] addr, input bit wr,
                       input logic [31:0] wdata, input logic [3:0] strb,
                       input bit chk_data, input logic [31:0] exp_data,
                       input bit exp_err, input string name);
        push_apb(d4, chk_data, exp_data, exp_err, name);
        sel4      = d4;
        b_paddr   = addr;
        b_pwrite  = wr;
        b_pwdata  = wdata;
        b_pwstrb  = strb;
        b_psel    = 1'b1;
        b_penable = 1'b0;
        @(posedge clk); #1;
        b_penable = 1'b1;
        @(posedge clk); #1;
        b_psel    = 1'b0;
        b_penable = 1'b0;
    endtask

    task automatic rd(input bit d4, input logic [15:0] addr, input logic [31:0] exp, input string name);
        apb(d4, addr, 1'b0, 32'd0, 4'd0, 1'b1, exp, 1'b0, name);
    endtask

    task automatic wr(input bit d4, input logic [15:0] addr, input logic [31:0] data,
                      input logic [3:0] strb, input string name);
        apb(d4, addr, 1'b1, data, strb, 1'b0, 32'd0, 1'b0, name);
    endtask

    initial begin
        total = 0; bad = 0; ending = 1'b0;
        b_psel = 1'b0; b_penable = 1'b0; b_pwrite = 1'b0; sel4 = 1'b0;
        b_paddr = '0; b_pwdata = '0; b_pwstrb = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state: 10 idle edges plus the setup edge give mtime = 11.
        idle(10);
        rd(0, 16'hBFF8, 32'd11, "mtime_lo_after_reset");
        irq(1, 0, 0, "irq_after_reset");
        rd(0, 16'h0000, 32'h0000_0000, "msip_reset");
        rd(0, 16'h4000, 32'hFFFF_FFFF, "cmp_lo_reset");
        rd(0, 16'h4004, 32'hFFFF_FFFF, "cmp_hi_reset");
        rd(0, 16'hBFFC, 32'h0000_0000, "mtime_hi_reset");

        // mtip rises one edge after mtime reaches 0x40.
        wr(0, 16'h4004, 32'h0, 4'hF, "wr_cmp_hi0");
        wr(0, 16'h4000, 32'h40, 4'hF, "wr_cmp_lo40");
        while (cyc < 64) idle(1);
        irq(1, 0, 0, "mtip_at_mtime40");
        idle(1);
        irq(1, 1, 0, "mtip_after_mtime40");
        wr(0, 16'h4000, 32'hFFFF_FFFF, 4'hF, "wr_cmp_lo_max");
        irq(1, 1, 0, "mtip_cmp_write_edge");
        idle(1);
        irq(1, 0, 0, "mtip_cmp_cleared");

        // Wrap of the low word carries into HI.
        wr(0, 16'hBFFC, 32'd5, 4'hF, "wr_mt_hi5_a");
        wr(0, 16'hBFF8, 32'hFFFF_FFFE, 4'hF, "wr_mt_lo_a");
        idle(1);
        rd(0, 16'hBFF8, 32'h0, "mtime_lo_wrapped");
        rd(0, 16'hBFFC, 32'd6, "mtime_hi_wrapped");

        // LO read at 0xFFFFFFFF, then HI after the wrap.
        wr(0, 16'hBFFC, 32'd5, 4'hF, "wr_mt_hi5_b");
        wr(0, 16'hBFF8, 32'hFFFF_FFFE, 4'hF, "wr_mt_lo_b");
        rd(0, 16'hBFF8, 32'hFFFF_FFFF, "mtime_lo_prewrap");
        rd(0, 16'hBFFC, EXP_HI_TEAR, "mtime_hi_tear");

        // MSIP and a high-word compare.
        wr(0, 16'h0000, 32'h3, 4'hF, "wr_msip3");
        irq(1, 1, 1, "msip_set");
        rd(0, 16'h0000, 32'h1, "msip_read1");
        wr(0, 16'h4004, 32'hFFFF_FFFF, 4'hF, "wr_cmp_hi_max");
        irq(1, 1, 1, "mtip_hi_write_edge");
        idle(1);
        irq(1, 0, 1, "mtip_hi_cleared");
        wr(0, 16'h0000, 32'h0, 4'hF, "wr_msip0");
        irq(1, 0, 0, "msip_clear");
        wr(0, 16'h0000, 32'hFFFF_FFFE, 4'hF, "wr_msip_upper");
        rd(0, 16'h0000, 32'h0, "msip_upper_bits");

        // Byte strobes and error responses.
        wr(0, 16'h4000, 32'hAABB_CCDD, 4'b0101, "wr_cmp_lo_strb");
        rd(0, 16'h4000, 32'hFFBB_FFDD, "cmp_lo_strb");
        apb(0, 16'h4002, 1'b1, 32'h0, 4'hF, 1'b0, 32'h0, 1'b1, "err_wr_4002");
        rd(0, 16'h4000, 32'hFFBB_FFDD, "cmp_lo_after_err");
        apb(0, 16'h0004, 1'b0, 32'h0, 4'h0, 1'b1, 32'h0, 1'b1, "err_rd_0004");
        apb(0, 16'hC000, 1'b0, 32'h0, 4'h0, 1'b1, 32'h0, 1'b1, "err_rd_c000");
        apb(0, 16'h0001, 1'b1, 32'h1, 4'hF, 1'b0, 32'h0, 1'b1, "err_wr_0001");
        irq(1, 0, 0, "msip_after_err_wr");
        wr(0, 16'h0000, 32'h1, 4'h0, "wr_msip_strb0");
        irq(1, 0, 0, "msip_strb0");

        // TICK_DIV=4: ticks land on edges where cyc % 4 == 0.
        while (cyc % 4 != 0) idle(1);
        wr(1, 16'hBFF8, 32'hCAFE_0000, 4'hF, "t4_wr_full");
        wr(1, 16'hBFF8, 32'h1234_5678, 4'b0001, "t4_wr_byte0");
        rd(1, 16'hBFF8, 32'hCAFE_0078, "t4_lo_strb");
        rd(1, 16'hBFF8, 32'hCAFE_0078, "t4_lo_no_tick");
        rd(1, 16'hBFF8, 32'hCAFE_0079, "t4_lo_one_tick");
        idle(4);
        rd(1, 16'hBFF8, 32'hCAFE_007A, "t4_lo_two_ticks");
        rd(1, 16'hBFFC, 32'h0, "t4_hi");

        // Asynchronous reset during an access phase.
        wr(0, 16'h0000, 32'h1, 4'hF, "wr_msip_pre_rst");
        irq(1, 0, 1, "msip_before_reset");
        push_apb(0, 1'b0, 32'h0, 1'b0, "aborted_write");
        sel4 = 1'b0; b_paddr = 16'h4000; b_pwrite = 1'b1; b_pwdata = 32'h0; b_pwstrb = 4'hF;
        b_psel = 1'b1; b_penable = 1'b0;
        @(posedge clk); #1;
        b_penable = 1'b1;
        #2 rst_n = 1'b0;
        irq(1, 0, 0, "reset_mid_access");
        @(posedge clk); #1;
        b_psel = 1'b0; b_penable = 1'b0;
        idle(1);
        rst_n = 1'b1;
        rd(0, 16'hBFF8, 32'd1, "mtime_lo_after_reset2");
        rd(0, 16'h4000, 32'hFFFF_FFFF, "cmp_lo_after_reset2");
        rd(0, 16'h0000, 32'h0, "msip_after_reset2");
        rd(0, 16'hBFFC, 32'h0, "mtime_hi_after_reset2");

        idle(2);
        ending = 1'b1;
        idle(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
